// File: rtl/cwalk_sched.sv
// Intersection phase scheduler: one shared phase timer sequences NS/EW green,
// walk, flashing-hand clearance and yellow, and latches crosswalk button requests.
module cwalk_sched #(
   parameter logic [3:0] GREEN_T = 4'd10,
   parameter logic [3:0] YEL_T   = 4'd3,
   parameter logic [3:0] WALK_T  = 4'd7,
   parameter logic [3:0] CLR_T   = 4'd9
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       req_ns,
   input  logic       req_ew,
   output logic [2:0] light_ns,
   output logic [2:0] light_ew,
   output logic       walk_ns,
   output logic       walk_ew,
   output logic       hand_ns,
   output logic       hand_ew,
   output logic       num_on,
   output logic [3:0] count,
   output logic       pend_ns,
   output logic       pend_ew
);

   typedef enum logic [2:0] {
      NS_GRN  = 3'd0,
      NS_WALK = 3'd1,
      NS_CLR  = 3'd2,
      NS_YEL  = 3'd3,
      EW_GRN  = 3'd4,
      EW_WALK = 3'd5,
      EW_CLR  = 3'd6,
      EW_YEL  = 3'd7
   } state_t;

   state_t     r_state;
   logic [3:0] r_timer;
   logic       r_blink;
   logic       r_pend_ns;
   logic       r_pend_ew;
   logic [2:0] r_light_ns;
   logic [2:0] r_light_ew;
   logic       r_walk_ns;
   logic       r_walk_ew;
   logic       r_hand_ns;
   logic       r_hand_ew;
   logic       r_num_on;
   logic [3:0] r_count;

   state_t     w_state_nxt;
   logic [3:0] w_timer_nxt;
   logic       w_blink_nxt;
   logic       w_pend_ns_nxt;
   logic       w_pend_ew_nxt;
   logic       w_is_clr_nxt;

   function automatic logic [3:0] f_load(input state_t s);
      logic [3:0] v;
      case (s)
         NS_GRN, EW_GRN:   v = GREEN_T - 4'd1;
         NS_WALK, EW_WALK: v = WALK_T - 4'd1;
         NS_CLR, EW_CLR:   v = CLR_T - 4'd1;
         NS_YEL, EW_YEL:   v = YEL_T - 4'd1;
         default:          v = GREEN_T - 4'd1;
      endcase
      return v;
   endfunction

   function automatic logic [2:0] f_light(input state_t s, input logic is_ns);
      logic g;
      logic y;
      if (is_ns) begin
         g = (s inside {NS_GRN, NS_WALK, NS_CLR});
         y = (s == NS_YEL);
      end else begin
         g = (s inside {EW_GRN, EW_WALK, EW_CLR});
         y = (s == EW_YEL);
      end
      return g ? 3'b001 : (y ? 3'b010 : 3'b100);
   endfunction

   // Next state, phase timer, clearance blink and request latches.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_blink_nxt = r_blink;
      if (tick) begin
         if (r_timer == 4'd0) begin
            case (r_state)
               NS_GRN:  w_state_nxt = NS_YEL;
               NS_WALK: w_state_nxt = NS_CLR;
               NS_CLR:  w_state_nxt = NS_YEL;
               NS_YEL:  w_state_nxt = (r_pend_ew | req_ew) ? EW_WALK : EW_GRN;
               EW_GRN:  w_state_nxt = EW_YEL;
               EW_WALK: w_state_nxt = EW_CLR;
               EW_CLR:  w_state_nxt = EW_YEL;
               EW_YEL:  w_state_nxt = (r_pend_ns | req_ns) ? NS_WALK : NS_GRN;
               default: w_state_nxt = NS_GRN;
            endcase
            w_timer_nxt = f_load(w_state_nxt);
            w_blink_nxt = 1'b1;
         end else begin
            w_timer_nxt = r_timer - 4'd1;
            w_blink_nxt = (r_state == NS_CLR || r_state == EW_CLR) ? ~r_blink : 1'b1;
         end
      end else begin
         w_state_nxt = r_state;
      end

      // A request arriving together with walk entry is served by that walk.
      if (w_state_nxt == NS_WALK && r_state != NS_WALK) begin
         w_pend_ns_nxt = 1'b0;
      end else if (r_state == NS_WALK) begin
         w_pend_ns_nxt = r_pend_ns;
      end else begin
         w_pend_ns_nxt = r_pend_ns | req_ns;
      end

      if (w_state_nxt == EW_WALK && r_state != EW_WALK) begin
         w_pend_ew_nxt = 1'b0;
      end else if (r_state == EW_WALK) begin
         w_pend_ew_nxt = r_pend_ew;
      end else begin
         w_pend_ew_nxt = r_pend_ew | req_ew;
      end

      w_is_clr_nxt = (w_state_nxt == NS_CLR) || (w_state_nxt == EW_CLR);
   end

   // State registers and outputs registered from the next-state decode.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= NS_GRN;
         r_timer    <= GREEN_T - 4'd1;
         r_blink    <= 1'b1;
         r_pend_ns  <= 1'b0;
         r_pend_ew  <= 1'b0;
         r_light_ns <= 3'b001;
         r_light_ew <= 3'b100;
         r_walk_ns  <= 1'b0;
         r_walk_ew  <= 1'b0;
         r_hand_ns  <= 1'b1;
         r_hand_ew  <= 1'b1;
         r_num_on   <= 1'b0;
         r_count    <= 4'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_timer    <= w_timer_nxt;
         r_blink    <= w_blink_nxt;
         r_pend_ns  <= w_pend_ns_nxt;
         r_pend_ew  <= w_pend_ew_nxt;
         r_light_ns <= f_light(w_state_nxt, 1'b1);
         r_light_ew <= f_light(w_state_nxt, 1'b0);
         r_walk_ns  <= (w_state_nxt == NS_WALK);
         r_walk_ew  <= (w_state_nxt == EW_WALK);
         r_hand_ns  <= (w_state_nxt == NS_CLR) ? w_blink_nxt : (w_state_nxt != NS_WALK);
         r_hand_ew  <= (w_state_nxt == EW_CLR) ? w_blink_nxt : (w_state_nxt != EW_WALK);
         r_num_on   <= w_is_clr_nxt;
         r_count    <= w_is_clr_nxt ? w_timer_nxt : 4'd0;
      end
   end

   assign light_ns = r_light_ns;
   assign light_ew = r_light_ew;
   assign walk_ns  = r_walk_ns;
   assign walk_ew  = r_walk_ew;
   assign hand_ns  = r_hand_ns;
   assign hand_ew  = r_hand_ew;
   assign num_on   = r_num_on;
   assign count    = r_count;
   assign pend_ns  = r_pend_ns;
   assign pend_ew  = r_pend_ew;

endmodule

// File: tb/tb_cwalk_sched.sv
// Scoreboard bench for cwalk_sched: stimulus queues the expected output vector
// for every tick, a monitor pops and compares after each sampled tick.
module tb_cwalk_sched;

   localparam int P_NSG = 0, P_NSW = 1, P_NSC = 2, P_NSY = 3;
   localparam int P_EWG = 4, P_EWW = 5, P_EWC = 6, P_EWY = 7;

   logic       clk, reset, tick, req_ns, req_ew;
   logic [2:0] light_ns, light_ew;
   logic       walk_ns, walk_ew, hand_ns, hand_ew, num_on, pend_ns, pend_ew;
   logic [3:0] count;
   logic [16:0] dut_vec;
   logic       tick_q;
   int         checks = 0;
   int         errors = 0;
   int         tick_n = 0;
   logic [16:0] exp_q[$];

   cwalk_sched dut (
      .clk(clk), .reset(reset), .tick(tick), .req_ns(req_ns), .req_ew(req_ew),
      .light_ns(light_ns), .light_ew(light_ew), .walk_ns(walk_ns), .walk_ew(walk_ew),
      .hand_ns(hand_ns), .hand_ew(hand_ew), .num_on(num_on), .count(count),
      .pend_ns(pend_ns), .pend_ew(pend_ew)
   );

   assign dut_vec = {light_ns, light_ew, walk_ns, walk_ew, hand_ns, hand_ew,
                     num_on, count, pend_ns, pend_ew};

   always #5 clk = ~clk;

   // Expected vector for a phase, remaining timer value and blink phase.
   function automatic logic [16:0] ev(int ph, int tmr, logic blink, logic pn, logic pe);
      logic [2:0] ln, le;
      logic       wn, we, hn, he, on;
      logic [3:0] t4;
      int         tv;
      tv = tmr;
      t4 = tv[3:0];
      ln = 3'b100; le = 3'b100;
      wn = 1'b0; we = 1'b0; hn = 1'b1; he = 1'b1; on = 1'b0;
      case (ph)
         P_NSG: ln = 3'b001;
         P_NSW: begin ln = 3'b001; wn = 1'b1; hn = 1'b0; end
         P_NSC: begin ln = 3'b001; hn = blink; on = 1'b1; end
         P_NSY: ln = 3'b010;
         P_EWG: le = 3'b001;
         P_EWW: begin le = 3'b001; we = 1'b1; he = 1'b0; end
         P_EWC: begin le = 3'b001; he = blink; on = 1'b1; end
         P_EWY: le = 3'b010;
         default: ln = 3'b111;
      endcase
      return {ln, le, wn, we, hn, he, on, (on ? t4 : 4'd0), pn, pe};
   endfunction

   task automatic chk(string nm, logic [16:0] act, logic [16:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %05h expected %05h", nm, act, exp);
      end
   endtask

   always @(posedge clk) tick_q <= tick;

   // Monitor: one expected vector per tick the DUT sampled.
   always @(negedge clk) begin
      if (tick_q === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tick%0d: got %05h expected none queued", tick_n, dut_vec);
         end else begin
            chk($sformatf("tick%0d", tick_n), dut_vec, exp_q.pop_front());
         end
         tick_n++;
      end
   end

   task automatic do_tick(logic rn, logic re);
      @(negedge clk); tick = 1'b1; req_ns = rn; req_ew = re;
      @(negedge clk); tick = 1'b0; req_ns = 1'b0; req_ew = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse(logic rn, logic re);
      @(negedge clk); req_ns = rn; req_ew = re;
      @(negedge clk); req_ns = 1'b0; req_ew = 1'b0;
   endtask

   // Samples j0..j1-1 of a phase of length t (timer t-1-j after sample j).
   task automatic run(int ph, int t, int j0, int j1, logic pn, logic pe);
      for (int j = j0; j < j1; j++) begin
         exp_q.push_back(ev(ph, t - 1 - j, (j % 2 == 0) ? 1'b1 : 1'b0, pn, pe));
         do_tick(1'b0, 1'b0);
      end
   endtask

   initial begin
      clk = 1'b0; reset = 1'b1; tick = 1'b0; req_ns = 1'b0; req_ew = 1'b0;
      #2 reset = 1'b0;
      #1 chk("reset_hold", dut_vec, ev(P_NSG, 9, 1'b1, 1'b0, 1'b0));
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_release", dut_vec, ev(P_NSG, 9, 1'b1, 1'b0, 1'b0));

      // Two full cycles without requests.
      for (int c = 0; c < 2; c++) begin
         run(P_NSG, 10, (c == 0) ? 1 : 0, 10, 1'b0, 1'b0);
         run(P_NSY, 3, 0, 3, 1'b0, 1'b0);
         run(P_EWG, 10, 0, 10, 1'b0, 1'b0);
         run(P_EWY, 3, 0, 3, 1'b0, 1'b0);
      end

      // NS request during green, ignored request in walk, stall in clearance.
      run(P_NSG, 10, 0, 1, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      run(P_NSG, 10, 1, 10, 1'b1, 1'b0);
      run(P_NSY, 3, 0, 3, 1'b1, 1'b0);
      run(P_EWG, 10, 0, 10, 1'b1, 1'b0);
      run(P_EWY, 3, 0, 3, 1'b1, 1'b0);
      run(P_NSW, 7, 0, 2, 1'b0, 1'b0);
      pulse(1'b1, 1'b0);
      run(P_NSW, 7, 2, 7, 1'b0, 1'b0);
      run(P_NSC, 9, 0, 4, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      pulse(1'b0, 1'b1);
      repeat (28) @(negedge clk);
      chk("stall_clr", dut_vec, ev(P_NSC, 5, 1'b0, 1'b0, 1'b1));
      pulse(1'b1, 1'b0);
      run(P_NSC, 9, 4, 9, 1'b1, 1'b1);
      run(P_NSY, 3, 0, 3, 1'b1, 1'b1);
      run(P_EWW, 7, 0, 7, 1'b1, 1'b0);
      run(P_EWC, 9, 0, 9, 1'b1, 1'b0);
      run(P_EWY, 3, 0, 3, 1'b1, 1'b0);
      run(P_NSW, 7, 0, 7, 1'b0, 1'b0);
      run(P_NSC, 9, 0, 9, 1'b0, 1'b0);
      run(P_NSY, 3, 0, 3, 1'b0, 1'b0);
      run(P_EWG, 10, 0, 10, 1'b0, 1'b0);
      run(P_EWY, 3, 0, 3, 1'b0, 1'b0);

      // Both requests in one cycle: EW walk first, then NS walk.
      run(P_NSG, 10, 0, 1, 1'b0, 1'b0);
      pulse(1'b1, 1'b1);
      run(P_NSG, 10, 1, 10, 1'b1, 1'b1);
      run(P_NSY, 3, 0, 3, 1'b1, 1'b1);
      run(P_EWW, 7, 0, 7, 1'b1, 1'b0);
      run(P_EWC, 9, 0, 9, 1'b1, 1'b0);
      run(P_EWY, 3, 0, 3, 1'b1, 1'b0);
      exp_q.push_back(ev(P_NSW, 6, 1'b1, 1'b0, 1'b0));
      do_tick(1'b1, 1'b0);
      run(P_NSW, 7, 1, 3, 1'b0, 1'b0);
      pulse(1'b0, 1'b1);
      run(P_NSW, 7, 3, 4, 1'b0, 1'b1);

      // Asynchronous reset in the middle of NS walk drops the pending request.
      @(negedge clk);
      #2 reset = 1'b0;
      #1 chk("async_reset", dut_vec, ev(P_NSG, 9, 1'b1, 1'b0, 1'b0));
      @(negedge clk);
      reset = 1'b1;
      run(P_NSG, 10, 1, 10, 1'b0, 1'b0);
      run(P_NSY, 3, 0, 3, 1'b0, 1'b0);
      run(P_EWG, 10, 0, 1, 1'b0, 1'b0);

      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
